// File: rtl/dsp_seq_pkg.sv
// Shared widths, feedback code and FSM state type for the FIR operand sequencer.
package dsp_seq_pkg;

    localparam int         A_W    = 20;
    localparam int         B_W    = 18;
    localparam int         Z_W    = 38;
    localparam logic [2:0] FB_MAC = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/dsp_fir_sequencer_if.sv
// Sample stream, coefficient write port and result stream of the FIR sequencer.
interface dsp_fir_sequencer_if;
    import dsp_seq_pkg::*;

    logic signed [A_W-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  coef_we;
    logic [5:0]            coef_addr;
    logic signed [B_W-1:0] coef_data;
    logic                  coef_busy;
    logic signed [Z_W-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output s_data, s_valid, coef_we, coef_addr, coef_data, m_ready,
        input  s_ready, coef_busy, m_data, m_valid
    );

    modport slave (
        input  s_data, s_valid, coef_we, coef_addr, coef_data, m_ready,
        output s_ready, coef_busy, m_data, m_valid
    );

endinterface

// File: rtl/dsp_coef_regfile.sv
// TAPS-entry signed coefficient store: one gated write port, one combinational read port.
module dsp_coef_regfile
    import dsp_seq_pkg::*;
#(
    parameter int TAPS = 8,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic                  clk,
    input  logic                  lreset,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic signed [B_W-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic signed [B_W-1:0] o_rdata
);

    logic signed [B_W-1:0] r_coef [TAPS];

    // Coefficient storage; reset clears every tap.
    always_ff @(posedge clk or negedge lreset) begin
        if (!lreset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (i_we) begin
            r_coef[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_coef[i_raddr];

endmodule

// File: rtl/dsp_fir_sequencer.sv
// Time-multiplexed FIR front end: feeds one multiply-accumulate per cycle to a
// REGOUT DSP block and returns the accumulated result on a valid/ready stream.
module dsp_fir_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int TAPS     = 8,
    parameter int DSP_LAT  = 1,
    parameter int SHIFT    = 0,
    parameter int ROUND    = 0,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  lreset,
    dsp_fir_sequencer_if.slave    io,
    output logic signed [A_W-1:0] dsp_a,
    output logic signed [B_W-1:0] dsp_b,
    output logic                  dsp_load_acc,
    output logic [2:0]            dsp_feedback,
    output logic                  dsp_unsigned_a,
    output logic                  dsp_unsigned_b,
    output logic                  dsp_subtract,
    output logic [5:0]            dsp_shift_right,
    output logic                  dsp_round,
    output logic                  dsp_saturate_enable,
    input  logic signed [Z_W-1:0] dsp_z
);

    localparam int AW = $clog2(TAPS);

    state_t                r_state;
    logic signed [A_W-1:0] r_x [TAPS];
    logic [AW-1:0]         r_tap;
    logic [1:0]            r_lat;
    logic signed [A_W-1:0] r_dsp_a;
    logic signed [B_W-1:0] r_dsp_b;
    logic                  r_load_acc;
    logic                  r_s_ready;
    logic                  r_coef_busy;
    logic                  r_m_valid;
    logic signed [Z_W-1:0] r_m_data;

    logic                  w_accept;
    logic                  w_coef_wen;
    logic [AW-1:0]         w_next_tap;
    logic [AW-1:0]         w_rd_idx;
    logic signed [B_W-1:0] w_coef_rd;
    logic signed [B_W-1:0] w_coef0;

    assign w_accept   = (r_state == IDLE) && r_s_ready && io.s_valid;
    assign w_coef_wen = io.coef_we && ({1'b0, io.coef_addr} < 7'(TAPS))
                        && ((r_state == IDLE) || (r_state == HOLD));
    assign w_next_tap = r_tap + AW'(1);
    assign w_rd_idx   = (r_state == MAC) ? w_next_tap : '0;
    // Forward a same-edge write of tap 0 so it applies to the sample being accepted.
    assign w_coef0    = (w_coef_wen && (io.coef_addr[AW-1:0] == '0)) ? io.coef_data : w_coef_rd;

    dsp_coef_regfile #(
        .TAPS (TAPS),
        .AW   (AW)
    ) u_coef (
        .clk     (clk),
        .lreset  (lreset),
        .i_we    (w_coef_wen),
        .i_waddr (io.coef_addr[AW-1:0]),
        .i_wdata (io.coef_data),
        .i_raddr (w_rd_idx),
        .o_rdata (w_coef_rd)
    );

    // Sequencer FSM with delay line and all registered outputs.
    always_ff @(posedge clk or negedge lreset) begin
        if (!lreset) begin
            r_state     <= IDLE;
            r_tap       <= '0;
            r_lat       <= 2'd0;
            r_dsp_a     <= '0;
            r_dsp_b     <= '0;
            r_load_acc  <= 1'b0;
            r_s_ready   <= 1'b0;
            r_coef_busy <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x[0] <= io.s_data;
                        for (int i = 1; i < TAPS; i++) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_dsp_a     <= io.s_data;
                        r_dsp_b     <= w_coef0;
                        r_load_acc  <= 1'b0;
                        r_tap       <= '0;
                        r_s_ready   <= 1'b0;
                        r_coef_busy <= 1'b1;
                        r_state     <= MAC;
                    end else begin
                        r_s_ready <= 1'b1;
                    end
                end
                MAC: begin
                    r_load_acc <= 1'b1;
                    if (r_tap == AW'(TAPS - 1)) begin
                        r_dsp_a <= '0;
                        r_dsp_b <= '0;
                        r_lat   <= 2'(DSP_LAT);
                        r_state <= DRAIN;
                    end else begin
                        r_tap   <= w_next_tap;
                        r_dsp_a <= r_x[w_next_tap];
                        r_dsp_b <= w_coef_rd;
                    end
                end
                DRAIN: begin
                    // Zero operands keep the accumulator unchanged while the DSP pipeline empties.
                    r_dsp_a    <= '0;
                    r_dsp_b    <= '0;
                    r_load_acc <= 1'b1;
                    if (r_lat == 2'd0) begin
                        r_m_data    <= dsp_z;
                        r_m_valid   <= 1'b1;
                        r_coef_busy <= 1'b0;
                        r_state     <= HOLD;
                    end else begin
                        r_lat <= r_lat - 2'd1;
                    end
                end
                HOLD: begin
                    if (io.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_m_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io.s_ready          = r_s_ready;
    assign io.coef_busy        = r_coef_busy;
    assign io.m_valid          = r_m_valid;
    assign io.m_data           = r_m_data;
    assign dsp_a               = r_dsp_a;
    assign dsp_b               = r_dsp_b;
    assign dsp_load_acc        = r_load_acc;
    assign dsp_feedback        = FB_MAC;
    assign dsp_unsigned_a      = 1'b0;
    assign dsp_unsigned_b      = 1'b0;
    assign dsp_subtract        = 1'b0;
    assign dsp_shift_right     = 6'(SHIFT);
    assign dsp_round           = 1'(ROUND);
    assign dsp_saturate_enable = 1'(SATURATE);

endmodule

// File: tb/tb_dsp_fir_sequencer.sv
// Bench for dsp_fir_sequencer: two instances (TAPS=4/LAT=1 and TAPS=2/LAT=3), each
// driving a behavioural multiply-accumulate model standing in for the DSP block.
module tb_dsp_fir_sequencer;
    import dsp_seq_pkg::*;

    logic clk = 1'b0;
    logic lreset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dsp_fir_sequencer_if if0 ();
    dsp_fir_sequencer_if if1 ();

    logic signed [A_W-1:0] a0, a1;
    logic signed [B_W-1:0] b0, b1;
    logic                  la0, la1, ua0, ua1, ub0, ub1, sub0, sub1, rnd0, rnd1, sat0, sat1;
    logic [2:0]            fb0, fb1;
    logic [5:0]            sh0, sh1;
    logic signed [Z_W-1:0] z0, z1, acc0, acc1, prod0, prod1, p1a, p1b;

    dsp_fir_sequencer #(.TAPS(4), .DSP_LAT(1), .SHIFT(0), .ROUND(0), .SATURATE(0)) u_dut0 (
        .clk(clk), .lreset(lreset), .io(if0),
        .dsp_a(a0), .dsp_b(b0), .dsp_load_acc(la0), .dsp_feedback(fb0),
        .dsp_unsigned_a(ua0), .dsp_unsigned_b(ub0), .dsp_subtract(sub0),
        .dsp_shift_right(sh0), .dsp_round(rnd0), .dsp_saturate_enable(sat0), .dsp_z(z0)
    );

    dsp_fir_sequencer #(.TAPS(2), .DSP_LAT(3), .SHIFT(0), .ROUND(0), .SATURATE(0)) u_dut1 (
        .clk(clk), .lreset(lreset), .io(if1),
        .dsp_a(a1), .dsp_b(b1), .dsp_load_acc(la1), .dsp_feedback(fb1),
        .dsp_unsigned_a(ua1), .dsp_unsigned_b(ub1), .dsp_subtract(sub1),
        .dsp_shift_right(sh1), .dsp_round(rnd1), .dsp_saturate_enable(sat1), .dsp_z(z1)
    );

    // Behavioural DSP: registered accumulator, plus two extra output stages for the LAT=3 instance.
    assign prod0 = a0 * b0;
    assign prod1 = a1 * b1;
    always @(posedge clk or negedge lreset) begin
        if (!lreset) begin
            acc0 <= '0; acc1 <= '0; p1a <= '0; p1b <= '0;
        end else begin
            acc0 <= (la0 ? acc0 : '0) + prod0;
            acc1 <= (la1 ? acc1 : '0) + prod1;
            p1a  <= acc1;
            p1b  <= p1a;
        end
    end
    assign z0 = acc0;
    assign z1 = p1b;

    logic signed [A_W-1:0] mx [4];
    logic signed [B_W-1:0] mc [4];
    logic [Z_W-1:0]        sb_data [$];
    logic [Z_W-1:0]        last_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [Z_W-1:0] model_out();
        longint s = 0;
        for (int k = 0; k < 4; k++) s = s + longint'(mx[k]) * longint'(mc[k]);
        return s[Z_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wcoef0(input logic [5:0] a, input logic [17:0] d);
        if0.coef_we = 1'b1; if0.coef_addr = a; if0.coef_data = d;
        tick();
        if0.coef_we = 1'b0;
    endtask

    task automatic send0(input logic [19:0] smp, output int t);
        int n = 0;
        while (if0.s_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("send_ready", {63'd0, if0.s_ready}, 64'd1);
        if0.s_data = smp; if0.s_valid = 1'b1;
        tick();
        t = cyc;
        if0.s_valid = 1'b0;
        for (int k = 3; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = smp;
        sb_data.push_back(model_out());
    endtask

    task automatic wait0(input string tag, input int t, input int lat);
        int n = 0;
        @(negedge clk);
        while (if0.m_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        chk({tag, "_lat"}, 64'(cyc - t), 64'(lat));
        last_exp = sb_data.pop_front();
        chk({tag, "_data"}, {26'd0, if0.m_data}, {26'd0, last_exp});
    endtask

    task automatic ack0(input string tag);
        if0.m_ready = 1'b1;
        tick();
        if0.m_ready = 1'b0;
        chk({tag, "_mvalid_drop"}, {63'd0, if0.m_valid}, 64'd0);
        chk({tag, "_s_ready"}, {63'd0, if0.s_ready}, 64'd1);
    endtask

    task automatic chk_rst0(input string tag);
        chk({tag, "_s_ready"}, {63'd0, if0.s_ready}, 64'd0);
        chk({tag, "_m_valid"}, {63'd0, if0.m_valid}, 64'd0);
        chk({tag, "_busy"}, {63'd0, if0.coef_busy}, 64'd0);
        chk({tag, "_m_data"}, {26'd0, if0.m_data}, 64'd0);
        chk({tag, "_dsp_a"}, {44'd0, a0}, 64'd0);
        chk({tag, "_dsp_b"}, {46'd0, b0}, 64'd0);
        chk({tag, "_load_acc"}, {63'd0, la0}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        lreset = 1'b0;
        if0.s_data = '0; if0.s_valid = 1'b0; if0.coef_we = 1'b0; if0.coef_addr = '0; if0.coef_data = '0; if0.m_ready = 1'b0;
        if1.s_data = '0; if1.s_valid = 1'b0; if1.coef_we = 1'b0; if1.coef_addr = '0; if1.coef_data = '0; if1.m_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin mx[k] = '0; mc[k] = '0; end

        // Reset state and constant DSP controls.
        #12;
        chk_rst0("reset");
        chk("const_fb", {61'd0, fb0}, 64'd0);
        chk("const_ctrl", {59'd0, ua0, ub0, sub0, rnd0, sat0}, 64'd0);
        chk("const_shift", {58'd0, sh0}, 64'd0);
        @(negedge clk); lreset = 1'b1;
        tick();
        chk("idle_s_ready", {63'd0, if0.s_ready}, 64'd1);

        // Impulse response through c = {1,2,3,4}.
        for (int k = 0; k < 4; k++) begin wcoef0(6'(k), 18'(k + 1)); mc[k] = 18'(k + 1); end
        chk("idle_busy", {63'd0, if0.coef_busy}, 64'd0);
        send0(20'd1, t);
        chk("op0_a", {44'd0, a0}, 64'd1);
        chk("op0_b", {46'd0, b0}, 64'd1);
        chk("op0_load", {63'd0, la0}, 64'd0);
        chk("mac_s_ready", {63'd0, if0.s_ready}, 64'd0);
        tick();
        chk("op1_b", {46'd0, b0}, 64'd2);
        chk("op1_load", {63'd0, la0}, 64'd1);
        wait0("imp0", t, 6); ack0("imp0");
        for (int i = 1; i < 4; i++) begin
            send0(20'd0, t); wait0("imp", t, 6); ack0("imp");
        end

        // Signed extremes: full-precision products accumulated modulo the 38-bit result.
        for (int k = 0; k < 4; k++) begin wcoef0(6'(k), 18'h20000); mc[k] = 18'h20000; end
        for (int i = 0; i < 4; i++) begin
            send0(20'h80000, t); wait0("ext", t, 6); ack0("ext");
        end

        // Backpressure: result held while m_ready stays low; pending sample not taken.
        send0(20'd3, t);
        wait0("bp", t, 6);
        if0.s_data = 20'd9; if0.s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_data", {26'd0, if0.m_data}, {26'd0, last_exp});
            chk("bp_hold_valid", {63'd0, if0.m_valid}, 64'd1);
            chk("bp_s_ready", {63'd0, if0.s_ready}, 64'd0);
        end
        if0.s_valid = 1'b0;
        ack0("bp");
        tick();
        chk("bp_not_consumed", {63'd0, if0.coef_busy}, 64'd0);

        // Coefficient gating: dropped while busy, honoured in HOLD, range-checked address.
        for (int k = 0; k < 4; k++) begin wcoef0(6'(k), 18'(k + 1)); mc[k] = 18'(k + 1); end
        send0(20'd10, t);
        chk("gate_busy", {63'd0, if0.coef_busy}, 64'd1);
        if0.coef_we = 1'b1; if0.coef_addr = 6'd2; if0.coef_data = 18'd7;
        tick();
        if0.coef_we = 1'b0;
        wait0("gate_mac", t, 6);
        if0.coef_we = 1'b1; if0.coef_addr = 6'd2; if0.coef_data = 18'd7;
        tick();
        if0.coef_we = 1'b0;
        mc[2] = 18'd7;
        chk("hold_busy", {63'd0, if0.coef_busy}, 64'd0);
        ack0("gate_mac");
        wcoef0(6'd6, 18'd100);
        if0.coef_we = 1'b1; if0.coef_addr = 6'd0; if0.coef_data = 18'd5;
        mc[0] = 18'd5;
        send0(20'd2, t);
        if0.coef_we = 1'b0;
        wait0("gate_hold", t, 6); ack0("gate_hold");

        // Reset in the middle of a MAC run.
        send0(20'd11, t);
        tick(); tick();
        lreset = 1'b0;
        #1;
        chk_rst0("rst_mid");
        sb_data.delete();
        for (int k = 0; k < 4; k++) begin mx[k] = '0; mc[k] = '0; end
        @(negedge clk); lreset = 1'b1;
        tick();
        wcoef0(6'd0, 18'd1); mc[0] = 18'd1;
        send0(20'd5, t); wait0("rst_after", t, 6); ack0("rst_after");

        // Second instance: TAPS=2, DSP_LAT=3, c = {3,-5}.
        if1.coef_we = 1'b1; if1.coef_addr = 6'd0; if1.coef_data = 18'd3;
        tick();
        if1.coef_addr = 6'd1; if1.coef_data = 18'h3FFFB;
        tick();
        if1.coef_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("l3_s_ready", {63'd0, if1.s_ready}, 64'd1);
            if1.s_data = (i == 0) ? 20'd2 : 20'd4; if1.s_valid = 1'b1;
            tick();
            t = cyc;
            if1.s_valid = 1'b0;
            chk("l3_load0", {63'd0, la1}, 64'd0);
            tick();
            chk("l3_load1", {63'd0, la1}, 64'd1);
            chk("l3_b1", {46'd0, b1}, {46'd0, 18'h3FFFB});
            n = 0;
            @(negedge clk);
            while (if1.m_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
            chk("l3_lat", 64'(cyc - t), 64'd6);
            chk("l3_data", {26'd0, if1.m_data}, (i == 0) ? 64'd6 : 64'd2);
            if1.m_ready = 1'b1;
            tick();
            if1.m_ready = 1'b0;
            chk("l3_mvalid_drop", {63'd0, if1.m_valid}, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
